// File: rtl/niu32_pkg.sv
// niu32_pkg: shared widths, MMIO window and arbiter state encoding
package niu32_pkg;
  localparam int WORD_SIZE = 32;
  localparam int MEM_ADDR_BITS = 13;
  localparam int MEM_WORD_OFFSET = 2;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_CPU = 2'd1,
    S_OWN_DMA = 2'd2
  } arb_state_t;
endpackage

// File: rtl/niu32_mem_arbiter.sv
// niu32_mem_arbiter: CPU/DMA arbiter onto one synchronous RAM port with DMA burst lock and starvation guard
module niu32_mem_arbiter #(
  parameter int WORD_SIZE = niu32_pkg::WORD_SIZE,
  parameter int MEM_ADDR_BITS = niu32_pkg::MEM_ADDR_BITS,
  parameter int MEM_WORD_OFFSET = niu32_pkg::MEM_WORD_OFFSET,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     cpu_req,
  input  logic                                     cpu_we,
  input  logic [WORD_SIZE-1:0]                     cpu_addr,
  input  logic [WORD_SIZE-1:0]                     cpu_wdata,
  output logic                                     cpu_gnt,
  output logic                                     cpu_rvalid,
  output logic [WORD_SIZE-1:0]                     cpu_rdata,
  input  logic                                     dma_req,
  input  logic                                     dma_we,
  input  logic                                     dma_last,
  input  logic [WORD_SIZE-1:0]                     dma_addr,
  input  logic [WORD_SIZE-1:0]                     dma_wdata,
  output logic                                     dma_gnt,
  output logic                                     dma_rvalid,
  output logic [WORD_SIZE-1:0]                     dma_rdata,
  output logic                                     mem_en,
  output logic                                     mem_we,
  output logic [MEM_ADDR_BITS-MEM_WORD_OFFSET-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]                     mem_wdata,
  input  logic [WORD_SIZE-1:0]                     mem_rdata
);
  import niu32_pkg::*;
  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
  arb_state_t state, state_nxt, arb;
  logic [1:0] starve, starve_inc;
  logic any_gnt, acc_mmio, rd_cpu, rd_dma, rd_mmio;
  logic [WORD_SIZE-1:0] acc_addr, rd_data, cpu_rdata_q, dma_rdata_q;
  assign cpu_gnt = (state == S_OWN_CPU) && cpu_req;
  assign dma_gnt = (state == S_OWN_DMA) && dma_req;
  assign any_gnt = cpu_gnt || dma_gnt;
  // Arbitration sees the starve count including this cycle's CPU accept
  always_comb begin
    starve_inc = (cpu_gnt && dma_req && starve != STARVE_MAX) ? starve + 2'd1 : starve;
    arb = (dma_req && (!cpu_req || starve_inc == STARVE_MAX)) ? S_OWN_DMA :
          cpu_req ? S_OWN_CPU : S_IDLE;
    state_nxt = (state == S_OWN_DMA && !(dma_gnt && dma_last)) ? S_OWN_DMA : arb;
  end
  assign acc_addr = dma_gnt ? dma_addr : cpu_addr;
  assign acc_mmio = (acc_addr & WORD_SIZE'(MMIO_BASE)) == WORD_SIZE'(MMIO_BASE);
  assign mem_en = any_gnt && !acc_mmio;
  assign mem_we = mem_en && (dma_gnt ? dma_we : cpu_we);
  assign mem_addr = any_gnt ? acc_addr[MEM_ADDR_BITS-1:MEM_WORD_OFFSET] : '0;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_gnt ? cpu_wdata : '0;
  assign rd_data = rd_mmio ? '0 : mem_rdata;
  assign cpu_rvalid = rd_cpu;
  assign dma_rvalid = rd_dma;
  assign cpu_rdata = rd_cpu ? rd_data : cpu_rdata_q;
  assign dma_rdata = rd_dma ? rd_data : dma_rdata_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nxt;
  end
  // Read return is routed by the owner tag captured at accept time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= 2'd0;
      rd_cpu <= 1'b0;
      rd_dma <= 1'b0;
      rd_mmio <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      starve <= (state_nxt == S_OWN_DMA && state != S_OWN_DMA) ? 2'd0 : starve_inc;
      rd_cpu <= cpu_gnt && !cpu_we;
      rd_dma <= dma_gnt && !dma_we;
      rd_mmio <= acc_mmio;
      if (rd_cpu) cpu_rdata_q <= rd_data;
      if (rd_dma) dma_rdata_q <= rd_data;
    end
  end
endmodule

// File: tb/tb_niu32_mem_arbiter.sv
// tb_niu32_mem_arbiter: randomized scoreboard bench with a rule-level arbitration and memory model
module tb_niu32_mem_arbiter;
  localparam int LIMIT = 3;
  typedef struct {int cyc; logic cg, dg, en, we; logic [10:0] addr; logic [31:0] wd;} cyc_t;
  typedef struct {int due; logic [31:0] d;} rd_t;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, dma_last = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [10:0] mem_addr;
  int errors = 0, checks = 0, cyc = 0;
  cyc_t q_cyc[$];
  rd_t q_cpu[$], q_dma[$];
  int m_owner = 0, m_starve = 0;
  logic [31:0] sh [2048];
  bit sh_wr [2048];
  logic [31:0] last_c = 0, last_d = 0;
  bit e_cg, e_dg;
  logic [31:0] ram [2048];
  bit ram_wr [2048];

  niu32_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [10:0] a);
    return a == 11'd4 ? 32'hDEADBEEF : {5'h15, a, 5'h0A, a};
  endfunction

  // Synchronous RAM environment, read data one cycle after mem_en
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    end

  function automatic logic [31:0] rand_addr();
    logic [15:0] hi;
    logic [2:0] mid;
    logic [10:0] wi;
    logic [1:0] lo;
    if ($urandom_range(0, 9) == 0) return {16'hFFFF, 16'($urandom)};
    hi = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'hFFFE));
    mid = 3'($urandom);
    wi = 11'($urandom_range(0, 15));
    lo = 2'($urandom);
    return {hi, mid, wi, lo};
  endfunction

  // Reference: who may be granted this cycle, what memory sees, and what each read returns
  task automatic model_eval();
    logic [31:0] a, wd;
    logic [10:0] wi;
    logic we, mmio;
    cyc_t c;
    rd_t r;
    int nxt;
    e_cg = (m_owner == 1) && cpu_req;
    e_dg = (m_owner == 2) && dma_req;
    a = e_dg ? dma_addr : cpu_addr;
    we = e_dg ? dma_we : cpu_we;
    wd = e_dg ? dma_wdata : cpu_wdata;
    wi = a[12:2];
    mmio = a[31:16] == 16'hFFFF;
    c.cyc = cyc; c.cg = e_cg; c.dg = e_dg; c.en = (e_cg || e_dg) && !mmio;
    c.we = we; c.addr = wi; c.wd = wd;
    q_cyc.push_back(c);
    if (e_cg || e_dg) begin
      if (!we) begin
        r.due = cyc + 1;
        r.d = mmio ? 32'h0 : (sh_wr[wi] ? sh[wi] : init_val(wi));
        if (e_dg) q_dma.push_back(r);
        else q_cpu.push_back(r);
      end else if (!mmio) begin
        sh[wi] = wd;
        sh_wr[wi] = 1'b1;
      end
    end
    if (e_cg && dma_req && m_starve < LIMIT) m_starve++;
    if (m_owner != 2 || (e_dg && dma_last)) begin
      nxt = (dma_req && (!cpu_req || m_starve == LIMIT)) ? 2 : cpu_req ? 1 : 0;
      if (nxt == 2 && m_owner != 2) m_starve = 0;
      m_owner = nxt;
    end
  endtask

  task automatic step(input logic cr, cw, input logic [31:0] ca, cd,
                      input logic dr, dw, dl, input logic [31:0] da, dd);
    @(posedge clk); #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_last = dl; dma_addr = da; dma_wdata = dd;
    model_eval();
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we} !== 6'b0 || cpu_rdata !== 0 ||
        dma_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL %s got gnt=%b%b rv=%b%b en=%b we=%b crd=%h drd=%h addr=%h wd=%h, all zero required",
               nm, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we, cpu_rdata, dma_rdata,
               mem_addr, mem_wdata);
    end
  endtask

  // Monitor: per-cycle grant/memory checks and read-return scoreboard
  initial begin
    cyc_t c;
    rd_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (q_cyc.size() > 0) begin
          c = q_cyc.pop_front();
          checks++;
          if (c.cyc != cyc || {cpu_gnt, dma_gnt, mem_en} !== {c.cg, c.dg, c.en} ||
              (c.en && (mem_we !== c.we || mem_addr !== c.addr)) ||
              (c.en && c.we && mem_wdata !== c.wd)) begin
            errors++;
            $display("FAIL grant cyc=%0d got gnt=%b%b en=%b we=%b addr=%h wd=%h required gnt=%b%b en=%b we=%b addr=%h wd=%h",
                     cyc, cpu_gnt, dma_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                     c.cg, c.dg, c.en, c.we, c.addr, c.wd);
          end
        end
        checks++;
        if (cpu_rvalid) begin
          if (q_cpu.size() == 0) begin
            errors++;
            $display("FAIL cpu_rvalid cyc=%0d got unexpected rvalid rdata=%h required none", cyc, cpu_rdata);
          end else begin
            r = q_cpu.pop_front();
            if (r.due != cyc || cpu_rdata !== r.d) begin
              errors++;
              $display("FAIL cpu_rdata cyc=%0d got %h required %h due cyc %0d", cyc, cpu_rdata, r.d, r.due);
            end
            last_c = r.d;
          end
        end else if (q_cpu.size() > 0 && q_cpu[0].due <= cyc) begin
          errors++;
          $display("FAIL cpu_rvalid cyc=%0d got 0 required 1 data %h", cyc, q_cpu[0].d);
          void'(q_cpu.pop_front());
        end else if (cpu_rdata !== last_c) begin
          errors++;
          $display("FAIL cpu_rdata_hold cyc=%0d got %h required %h", cyc, cpu_rdata, last_c);
        end
        checks++;
        if (dma_rvalid) begin
          if (q_dma.size() == 0) begin
            errors++;
            $display("FAIL dma_rvalid cyc=%0d got unexpected rvalid rdata=%h required none", cyc, dma_rdata);
          end else begin
            r = q_dma.pop_front();
            if (r.due != cyc || dma_rdata !== r.d) begin
              errors++;
              $display("FAIL dma_rdata cyc=%0d got %h required %h due cyc %0d", cyc, dma_rdata, r.d, r.due);
            end
            last_d = r.d;
          end
        end else if (q_dma.size() > 0 && q_dma[0].due <= cyc) begin
          errors++;
          $display("FAIL dma_rvalid cyc=%0d got 0 required 1 data %h", cyc, q_dma[0].d);
          void'(q_dma.pop_front());
        end else if (dma_rdata !== last_d) begin
          errors++;
          $display("FAIL dma_rdata_hold cyc=%0d got %h required %h", cyc, dma_rdata, last_d);
        end
      end
    end
  end

  initial begin
    int n, beat, gap, db;
    #2 reset = 0;
    #1 check_zero("reset_initial");
    repeat (3) @(posedge clk);
    #1 reset = 1;
    // CPU read of word 4
    n = 0;
    do begin step(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 0); n++; end while (!e_cg && n < 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // MMIO read returns zero without touching memory
    n = 0;
    do begin step(1, 0, 32'hFFFF_0120, 0, 0, 0, 0, 0, 0); n++; end while (!e_cg && n < 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Both requesters held high: starvation guard hands over to DMA
    db = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1, 0, (db % 2 == 1), 32'h200 + 4 * db, 0);
      if (e_dg) db++;
    end
    n = 0;
    while (m_owner == 2 && n < 10) begin step(0, 0, 0, 0, 1, 0, 1, 32'h300, 0); n++; end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // DMA write burst with a two-cycle request gap on beat 3
    beat = 0; gap = 0; n = 0;
    while (beat < 4 && n < 60) begin
      step(1, 0, rand_addr(), 0, !(beat == 2 && gap < 2), 1, beat == 3, 32'h100 + 4 * beat, 32'hB0B0_0000 + beat);
      if (e_dg) beat++;
      else if (beat == 2 && !dma_req) gap++;
      n++;
    end
    step(1, 0, 32'h0000_0104, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h0000_0108, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           rand_addr(), $urandom);
    n = 0;
    while (m_owner == 2 && n < 10) begin step(0, 0, 0, 0, 1, 1, 1, 32'h300, 0); n++; end
    // Reset the cycle after a DMA read accept
    n = 0;
    do begin step(0, 0, 0, 0, 1, 0, 0, 32'h0000_0040, 0); n++; end while (!e_dg && n < 10);
    @(posedge clk); #1;
    cpu_req = 1;
    reset = 0;
    #1 check_zero("reset_async");
    q_cyc.delete(); q_cpu.delete(); q_dma.delete();
    m_owner = 0; m_starve = 0; last_c = 0; last_d = 0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_hold");
    cpu_req = 0; dma_req = 0;
    reset = 1;
    n = 0;
    do begin step(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 0); n++; end while (!e_cg && n < 5);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_cpu.size() != 0 || q_dma.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d cpu %0d dma reads outstanding required 0", q_cpu.size(), q_dma.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
